// File: rtl/mux_pkg.sv
// Shared types for the stream multiplexer: arbitration mode, lock state and
// the channel-index width helper.
package mux_pkg;

    typedef enum logic {ARB_RR = 1'b0, ARB_FIXED = 1'b1} arb_mode_t;
    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

    // A single channel still needs a one-bit index so out_ch has a width.
    function automatic int ch_idx_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: fixed priority (lowest index) or round-robin
// starting the search at ptr.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = ch_idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    input  arb_mode_t         mode,
    output logic              gnt_valid,
    output logic [CH_W-1:0]   gnt_idx
);

    // cand_idx[k] is the channel examined k-th in the round-robin search.
    logic [CH_W-1:0] cand_idx [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
            assign cand_idx[gi] = CH_W'((int'(ptr) + gi) % NUM_CH);
        end
    endgenerate

    // Scan from the far end so the earliest candidate overwrites the rest.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (mode == ARB_FIXED) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (req[i]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = CH_W'(i);
                end
            end
        end else begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (req[cand_idx[k]]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = cand_idx[k];
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel stream multiplexer with packet locking and a one-entry registered
// output stage; channel choice comes from rr_arbiter while unlocked.
module stream_mux_arb
    import mux_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int CH_W   = ch_idx_width(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH-1:0]       in_last,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    prio_mode,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [CH_W-1:0]         out_ch,
    input  logic                    out_ready
);

    lock_state_t      state_reg;
    logic [CH_W-1:0]  lock_ch_reg;
    logic [CH_W-1:0]  rr_ptr_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_valid_reg;
    logic             out_last_reg;
    logic [CH_W-1:0]  out_ch_reg;

    logic [WIDTH-1:0] ch_data [NUM_CH];
    logic             arb_valid;
    logic [CH_W-1:0]  arb_idx;
    logic             grant_valid;
    logic [CH_W-1:0]  grant_idx;
    logic             can_accept;
    logic             accept;
    logic [CH_W-1:0]  rr_ptr_next;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
            assign in_ready[gi] = accept && (grant_idx == CH_W'(gi));
        end
    endgenerate

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr_reg),
        .mode      (arb_mode_t'(prio_mode)),
        .gnt_valid (arb_valid),
        .gnt_idx   (arb_idx)
    );

    // A locked packet owns the output; the arbiter (and prio_mode) is ignored.
    always_comb begin
        grant_valid = arb_valid;
        grant_idx   = arb_idx;
        if (state_reg == LOCKED) begin
            grant_valid = in_valid[lock_ch_reg];
            grant_idx   = lock_ch_reg;
        end
    end

    assign can_accept  = !out_valid_reg || out_ready;
    assign accept      = !reset && can_accept && grant_valid;
    assign rr_ptr_next = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= UNLOCKED;
            lock_ch_reg   <= '0;
            rr_ptr_reg    <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_ch_reg    <= '0;
        end else if (accept) begin
            out_data_reg  <= ch_data[grant_idx];
            out_last_reg  <= in_last[grant_idx];
            out_ch_reg    <= grant_idx;
            out_valid_reg <= 1'b1;
            if (in_last[grant_idx]) begin
                state_reg  <= UNLOCKED;
                rr_ptr_reg <= rr_ptr_next;
            end else begin
                state_reg   <= LOCKED;
                lock_ch_reg <= grant_idx;
            end
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign out_ch    = out_ch_reg;

endmodule

// File: doc/stream_mux_arb.md
# stream_mux_arb

Parametrised N-channel, WIDTH-bit stream multiplexer with valid/ready handshakes, packet locking and selectable round-robin or fixed-priority arbitration. It generalises the lab's 2:1 bus selector: the channel is chosen by an internal arbiter, not by an external select. The winning beat is registered into a one-entry output stage. The block sits between several datapath producers and a single shared consumer, such as a display or result bus.

## Interface
- WIDTH, default 8: data bits per channel.
- NUM_CH, default 4: number of input channels (≥1).
- CH_W, default $clog2(NUM_CH) (min 1): channel-index width.

- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is high.
- in_data  in  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NUM_CH  channel i offers a beat.
- in_last  in  NUM_CH  beat is final beat of its packet.
- in_ready  out  NUM_CH  channel i beat accepted this cycle when in_valid[i] and in_ready[i].
- prio_mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- out_data  out  WIDTH  registered beat.
- out_valid  out  1  output stage holds a beat.
- out_last  out  1  registered in_last of that beat.
- out_ch  out  CH_W  source channel of that beat.
- out_ready  in  1  consumer accepts when out_valid and out_ready.

## Operation
- Two states: UNLOCKED and LOCKED (holding lock_ch).
- can_accept = !out_valid || out_ready. Back-to-back full throughput is allowed.
- Grant:
  - LOCKED: grant = lock_ch if in_valid[lock_ch]. Otherwise no grant. Other channels wait even if valid.
  - UNLOCKED, prio_mode=1: lowest i with in_valid[i].
  - UNLOCKED, prio_mode=0: first valid i searching rr_ptr, rr_ptr+1, … mod NUM_CH.
  - No valid inputs: no grant.
- in_ready[i] = can_accept && grant valid && i == grant. At most one bit is set. in_ready may depend combinationally on in_valid. Producers must not make in_valid depend on in_ready.
- On accept of channel g:
  - Load out_data, out_last, out_ch = g, and set out_valid = 1.
  - If !in_last[g]: state becomes LOCKED with lock_ch = g.
  - If in_last[g]: state becomes UNLOCKED, and rr_ptr = (g+1) mod NUM_CH in both modes.
- If out_ready while out_valid and no new accept: out_valid becomes 0 next cycle. Data is held; its value is don't-care.
- prio_mode is sampled only in UNLOCKED. Changing it mid-packet has no effect until the packet ends.
- NUM_CH=1: the arbiter degenerates to a pass-through register. out_ch is always 0.

## Timing
- Latency: input accept edge → out_valid the next cycle (1 cycle).
- Throughput: 1 beat/cycle while out_ready stays high.
- Output stability: while out_valid && !out_ready, out_data, out_last and out_ch are held constant and no input is accepted.
- Reset values: out_valid 0, out_data 0, out_last 0, out_ch 0, rr_ptr 0, state UNLOCKED, all in_ready 0 during reset.
- Reset mid-packet: the lock and any buffered beat are discarded. No partial-packet recovery is attempted.
- Simultaneous drain and accept in one cycle: the new beat replaces the old one. No bubble is inserted.
- rr_ptr wrap: NUM_CH-1 + 1 → 0.

## Structure
- Package mux_pkg holds:
  - typedef enum logic {ARB_RR=1'b0, ARB_FIXED=1'b1} arb_mode_t;
  - typedef enum logic {UNLOCKED, LOCKED} lock_state_t.
- Sub-module rr_arbiter: purely combinational.
  - Parameters: NUM_CH.
  - Inputs: req[NUM_CH], ptr[CH_W], mode.
  - Outputs: gnt_valid, gnt_idx[CH_W].
- The top level holds the lock FSM, rr_ptr, and the output register.

## Test plan
- Reset: assert reset 2 cycles with all in_valid=1 → in_ready=0, out_valid=0, out_data=0 throughout. The first accept is on the edge after reset deasserts.
- Round-robin fairness: NUM_CH=4, all channels valid with single-beat packets (last=1), out_ready=1 → out_ch sequence 0,1,2,3,0,1 with one beat per cycle.
- Fixed priority: prio_mode=1, channels 1 and 3 valid with last=1 → only channel 1 is served while it stays valid. Drop ch1 valid → ch3 is served next cycle.
- Packet lock: ch2 sends 3 beats (0xA1, 0xA2, 0xA3 with last on the third) while ch0 is valid. Gap ch2 valid for 1 cycle mid-packet → out carries A1, A2, A3 contiguously from ch2, and ch0 is served only after A3. rr_ptr becomes 3.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1, data 0x5C → output is held at 0x5C, all in_ready=0. out_ready=1 → 0x5C drains and the next beat loads in the same cycle.
- Reset mid-packet: reset after 1 of 3 beats from ch1 → state UNLOCKED and out_valid=0. Afterwards ch0 (valid) is served first with rr_ptr=0.
